// File: rtl/block_uart_streamer_if.sv
// Bundle of every non-clock/reset signal of block_uart_streamer.
//   master modport : the streamer (drives ch_ready, uart_wr, uart_dat, busy, done, done_ch)
//   slave modport  : producers + UART + supervisor (drive ch_valid, ch_data, hex_mode, uart_busy)
//   ch_valid/ch_ready : per-channel block handshake
//   ch_data           : channel c block = bits [c*BLOCK_BYTES*8 +: BLOCK_BYTES*8]
//   hex_mode          : 0 binary, 1 ASCII hex + CR LF
//   uart_wr/uart_dat/uart_busy : byte UART write port
//   busy/done/done_ch : block-level status
interface block_uart_streamer_if #(
  parameter int NUM_CH      = 2,
  parameter int BLOCK_BYTES = 16
);
  logic [NUM_CH-1:0]               ch_valid;
  logic [NUM_CH*BLOCK_BYTES*8-1:0] ch_data;
  logic [NUM_CH-1:0]               ch_ready;
  logic                            hex_mode;
  logic                            uart_wr;
  logic [7:0]                      uart_dat;
  logic                            uart_busy;
  logic                            busy;
  logic                            done;
  logic [1:0]                      done_ch;

  modport master (
    input  ch_valid, ch_data, hex_mode, uart_busy,
    output ch_ready, uart_wr, uart_dat, busy, done, done_ch
  );

  modport slave (
    output ch_valid, ch_data, hex_mode, uart_busy,
    input  ch_ready, uart_wr, uart_dat, busy, done, done_ch
  );
endinterface

// File: rtl/block_uart_streamer.sv
// Multi-channel block-to-UART serializer. Accepts one BLOCK_BYTES block at a time from
// NUM_CH producers (round-robin), then streams it to a byte UART as raw binary or as
// uppercase ASCII hex followed by CR LF, optionally preceded by a header byte A0|ch.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : block_uart_streamer_if.master (producer handshake, UART port, status)
// All outputs are registered.
module block_uart_streamer #(
  parameter int BLOCK_BYTES  = 16,
  parameter int NUM_CH       = 2,
  parameter int HEADER_EN    = 1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  block_uart_streamer_if.master  bus
);

  localparam int BLK_W      = BLOCK_BYTES * 8;
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW         = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int HDR        = (HEADER_EN != 0) ? 1 : 0;
  localparam int NSYM_BIN   = BLOCK_BYTES + HDR;
  localparam int NSYM_HEX   = 2 * NSYM_BIN + 2;
  // Sized for the hex symbol count so the index never wraps (6 bits at the default size).
  localparam int IDXW       = $clog2(NSYM_HEX);
  localparam int GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  localparam logic [IDXW-1:0] LAST_BIN   = IDXW'(NSYM_BIN - 1);
  localparam logic [IDXW-1:0] LAST_HEX   = IDXW'(NSYM_HEX - 1);
  localparam logic [IDXW-1:0] CRLF_START = IDXW'(2 * NSYM_BIN);
  localparam logic [IDXW-1:0] HDR_V      = IDXW'(HDR);
  localparam logic [IDXW-1:0] BB_V       = IDXW'(BLOCK_BYTES);
  localparam logic [7:0]      GUARD_V    = 8'(GUARD_LAST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WR    = 3'd2,
    S_GUARD = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    case (nib)
      4'h0: c = 8'h30;  4'h1: c = 8'h31;  4'h2: c = 8'h32;  4'h3: c = 8'h33;
      4'h4: c = 8'h34;  4'h5: c = 8'h35;  4'h6: c = 8'h36;  4'h7: c = 8'h37;
      4'h8: c = 8'h38;  4'h9: c = 8'h39;  4'hA: c = 8'h41;  4'hB: c = 8'h42;
      4'hC: c = 8'h43;  4'hD: c = 8'h44;  4'hE: c = 8'h45;  4'hF: c = 8'h46;
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  state_t            state_r, next_state_s;
  logic [CW-1:0]     rr_r, ch_r, sel_ch_s, cand_s;
  logic              hex_r, found_s, any_valid_s, accept_s, last_sym_s;
  logic [BLK_W-1:0]  shadow_r, blk_sel_s;
  logic [IDXW-1:0]   idx_r, raw_idx_s, pay_idx_s;
  logic [7:0]        gcnt_r;
  logic [7:0]        pay_s [BLOCK_BYTES];
  logic [7:0]        byte_s, sym_s;

  logic [NUM_CH-1:0] ch_ready_r;
  logic              uart_wr_r, busy_r, done_r;
  logic [7:0]        uart_dat_r;
  logic [1:0]        done_ch_r;

  assign bus.ch_ready = ch_ready_r;
  assign bus.uart_wr  = uart_wr_r;
  assign bus.uart_dat = uart_dat_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.done_ch  = done_ch_r;

  // Round-robin pick: first valid channel at or after the pointer, wrapping.
  always_comb begin
    any_valid_s = |bus.ch_valid;
    found_s     = 1'b0;
    sel_ch_s    = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = CW'((int'(rr_r) + k) % NUM_CH);
      if (!found_s && bus.ch_valid[cand_s]) begin
        found_s  = 1'b1;
        sel_ch_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Block slice of the selected channel (constant-index mux).
  always_comb begin
    blk_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch_s == CW'(c)) begin
        blk_sel_s = bus.ch_data[c*BLK_W +: BLK_W];
      end else begin
        blk_sel_s = blk_sel_s;
      end
    end
  end

  // Byte view of the shadow register; element 0 is the most significant byte.
  always_comb begin
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      pay_s[i] = shadow_r[(BLOCK_BYTES-1-i)*8 +: 8];
    end
  end

  // Symbol at the current index. In hex mode two symbols map to one raw byte.
  always_comb begin
    sym_s     = 8'h00;
    byte_s    = 8'h00;
    raw_idx_s = hex_r ? (idx_r >> 1) : idx_r;
    pay_idx_s = raw_idx_s - HDR_V;
    if ((HDR == 1) && (raw_idx_s == '0)) begin
      byte_s = 8'hA0 | 8'(ch_r);
    end else if (pay_idx_s < BB_V) begin
      byte_s = pay_s[pay_idx_s[IW-1:0]];
    end else begin
      byte_s = 8'h00;
    end
    if (hex_r && (idx_r >= CRLF_START)) begin
      sym_s = idx_r[0] ? 8'h0A : 8'h0D;
    end else if (hex_r) begin
      sym_s = idx_r[0] ? hex_ascii(byte_s[3:0]) : hex_ascii(byte_s[7:4]);
    end else begin
      sym_s = byte_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    accept_s     = (state_r == S_IDLE) && any_valid_s;
    last_sym_s   = hex_r ? (idx_r == LAST_HEX) : (idx_r == LAST_BIN);
    case (state_r)
      S_IDLE:  next_state_s = any_valid_s ? S_LOAD : S_IDLE;
      S_LOAD:  next_state_s = S_WR;
      S_WR:    next_state_s = (GUARD_CYCLES > 0) ? S_GUARD : S_WAIT;
      // The UART raises busy a few cycles late, so it is not looked at here.
      S_GUARD: next_state_s = (gcnt_r == GUARD_V) ? S_WAIT : S_GUARD;
      S_WAIT:  next_state_s = bus.uart_busy ? S_WAIT : S_NEXT;
      S_NEXT:  next_state_s = last_sym_s ? S_DONE : S_LOAD;
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r       <= '0;
      ch_r       <= '0;
      hex_r      <= 1'b0;
      shadow_r   <= '0;
      idx_r      <= '0;
      gcnt_r     <= 8'h00;
      ch_ready_r <= '0;
      uart_wr_r  <= 1'b0;
      uart_dat_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      done_ch_r  <= 2'b00;
    end else begin
      ch_ready_r <= accept_s ? (NUM_CH'(1) << sel_ch_s) : '0;
      uart_wr_r  <= (next_state_s == S_WR);
      busy_r     <= (next_state_s == S_LOAD) || (next_state_s == S_WR) ||
                    (next_state_s == S_GUARD) || (next_state_s == S_WAIT) ||
                    (next_state_s == S_NEXT);
      done_r     <= (next_state_s == S_DONE);
      if (next_state_s == S_DONE) begin
        done_ch_r <= 2'(ch_r);
      end
      if (accept_s) begin
        shadow_r <= blk_sel_s;
        hex_r    <= bus.hex_mode;
        ch_r     <= sel_ch_s;
        idx_r    <= '0;
      end
      if (state_r == S_LOAD) begin
        uart_dat_r <= sym_s;
      end
      if (state_r == S_WR) begin
        gcnt_r <= 8'h00;
      end else if (state_r == S_GUARD) begin
        gcnt_r <= gcnt_r + 8'h01;
      end
      if ((state_r == S_NEXT) && !last_sym_s) begin
        idx_r <= idx_r + IDXW'(1);
      end
      if (state_r == S_DONE) begin
        rr_r <= (ch_r == CW'(NUM_CH - 1)) ? '0 : ch_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_uart_streamer.sv
// Self-checking bench for block_uart_streamer (NUM_CH=2, BLOCK_BYTES=16, HEADER_EN=1).
// A table of block transfers, a reset-mid-block sequence and random transfers are each
// compared against a symbol-list reference model and a round-robin pointer model.
module tb_block_uart_streamer;

  localparam int NCH   = 2;
  localparam int BB    = 16;
  localparam int BOUND = 4000;
  localparam logic [127:0] D0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [1:0] mask;
    logic       hold;
    logic       hexm;
    int         blen;
    int         nblk;
    logic       chg;
    int         exp_count;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  logic clk;
  logic rst_n;
  block_uart_streamer_if #(.NUM_CH(NCH), .BLOCK_BYTES(BB)) bus ();

  block_uart_streamer #(
    .BLOCK_BYTES(BB), .NUM_CH(NCH), .HEADER_EN(1), .GUARD_CYCLES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           viol   = 0;
  int           busy_len = 0;
  int           rr_m   = 0;
  logic         prev_wr = 1'b0;
  logic         prev_done = 1'b0;
  logic [1:0]   valid_m = 2'b00;
  logic [127:0] data_c [NCH];
  logic [7:0]   got_q [$];
  logic [7:0]   exp_q [$];
  vec_t         vecs [7];

  // UART model: busy rises one cycle after the strobe and stays up busy_len cycles.
  initial begin
    int left;
    logic start;
    left = 0;
    start = 1'b0;
    bus.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        left = 0; start = 1'b0; bus.uart_busy = 1'b0;
      end else begin
        if (start) begin left = busy_len; start = 1'b0; end
        if (bus.uart_wr) start = 1'b1;
        if (left > 0) begin bus.uart_busy = 1'b1; left--; end
        else bus.uart_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive();
    bus.ch_valid = valid_m;
    bus.ch_data  = {data_c[1], data_c[0]};
  endtask

  // One cycle; records strobes and protocol violations on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.uart_wr) begin
      got_q.push_back(bus.uart_dat);
      if (prev_wr) viol++;
    end
    if (bus.done && prev_done) viol++;
    if (bus.uart_busy && got_q.size() > 0 && bus.uart_dat !== got_q[$]) viol++;
    prev_wr   = bus.uart_wr;
    prev_done = bus.done;
  endtask

  function automatic logic [7:0] asc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference symbol list for one block.
  function automatic void build(input logic [127:0] blk, input int ch, input logic hexm);
    logic [7:0] raw [$];
    exp_q.delete();
    raw.push_back(8'(160 + ch));
    for (int i = 0; i < BB; i++) raw.push_back(8'(blk >> (8 * (BB - 1 - i))));
    foreach (raw[i]) begin
      if (hexm) begin
        exp_q.push_back(asc(int'(raw[i]) / 16));
        exp_q.push_back(asc(int'(raw[i]) % 16));
      end else begin
        exp_q.push_back(raw[i]);
      end
    end
    if (hexm) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic int pick(input logic [1:0] m, input int rr);
    for (int k = 0; k < NCH; k++) begin
      if (m[(rr + k) % NCH]) return (rr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic run_vec(input logic [1:0] mask, input logic hold, input logic hexm,
                         input int blen, input int nblk, input logic chg,
                         output int cnt0, output logic [7:0] first0, output logic [7:0] last0);
    int waited, c, mism;
    cnt0 = -1; first0 = 8'h00; last0 = 8'h00;
    busy_len = blen;
    bus.hex_mode = hexm;
    valid_m = mask;
    drive();
    for (int b = 0; b < nblk; b++) begin
      c = pick(valid_m, rr_m);
      waited = 0;
      while (bus.ch_ready == 2'b00 && waited < BOUND) begin tick(); waited++; end
      if (waited >= BOUND) begin
        check("accept_timeout", 32'(waited), 32'(0));
        valid_m = 2'b00; drive();
        return;
      end
      check("ch_ready", 32'(bus.ch_ready), 32'(1 << c));
      check("busy_at_accept", 32'(bus.busy), 32'(1));
      build(data_c[c], c, hexm);
      got_q.delete();
      if (!hold) begin valid_m[c] = 1'b0; drive(); end
      if (chg) begin tick(); data_c[c] = ~data_c[c]; drive(); end
      waited = 0;
      while (!bus.done && waited < BOUND) begin tick(); waited++; end
      if (waited >= BOUND) begin
        check("done_timeout", 32'(waited), 32'(0));
        valid_m = 2'b00; drive();
        return;
      end
      if (b == nblk - 1) begin valid_m = 2'b00; drive(); end
      check("done_ch", 32'(bus.done_ch), 32'(c));
      check("busy_at_done", 32'(bus.busy), 32'(0));
      check("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
      mism = 0;
      foreach (exp_q[i]) begin
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
      end
      check("stream_bytes", 32'(mism), 32'(0));
      if (b == 0 && got_q.size() > 0) begin
        cnt0 = got_q.size(); first0 = got_q[0]; last0 = got_q[$];
      end
      rr_m = (c + 1) % NCH;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] f, l;
    logic [1:0] m;
    int waited;

    vecs[0] = '{2'b01, 1'b0, 1'b0, 3,  1, 1'b0, 17, 8'hA0, 8'h5A};
    vecs[1] = '{2'b01, 1'b0, 1'b1, 2,  1, 1'b0, 36, 8'h41, 8'h0A};
    vecs[2] = '{2'b10, 1'b0, 1'b0, 0,  1, 1'b0, 17, 8'hA1, 8'hFF};
    vecs[3] = '{2'b11, 1'b0, 1'b0, 2,  2, 1'b0, 17, 8'hA0, 8'h5A};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 1,  4, 1'b0, 17, 8'hA0, 8'h5A};
    vecs[5] = '{2'b01, 1'b0, 1'b0, 50, 1, 1'b0, 17, 8'hA0, 8'h5A};
    vecs[6] = '{2'b10, 1'b0, 1'b0, 4,  1, 1'b1, 17, 8'hA1, 8'hFF};

    data_c[0] = D0;
    data_c[1] = D1;
    valid_m = 2'b00;
    bus.hex_mode = 1'b0;
    drive();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ch_ready", 32'(bus.ch_ready), 32'(0));
    check("rst_uart_wr",  32'(bus.uart_wr),  32'(0));
    check("rst_uart_dat", 32'(bus.uart_dat), 32'(0));
    check("rst_busy",     32'(bus.busy),     32'(0));
    check("rst_done",     32'(bus.done),     32'(0));
    check("rst_done_ch",  32'(bus.done_ch),  32'(0));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_vec(vecs[i].mask, vecs[i].hold, vecs[i].hexm, vecs[i].blen,
              vecs[i].nblk, vecs[i].chg, cnt, f, l);
      check($sformatf("vec%0d_count", i), 32'(cnt), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_first", i), 32'(f),   32'(vecs[i].exp_first));
      check($sformatf("vec%0d_last", i),  32'(l),   32'(vecs[i].exp_last));
      repeat (2) tick();
    end

    // Reset in the middle of the payload, then a fresh block must start at the header.
    data_c[0] = D0;
    busy_len = 2;
    bus.hex_mode = 1'b0;
    valid_m = 2'b01;
    drive();
    waited = 0;
    while (bus.ch_ready == 2'b00 && waited < BOUND) begin tick(); waited++; end
    valid_m = 2'b00;
    drive();
    got_q.delete();
    waited = 0;
    while (got_q.size() < 6 && waited < BOUND) begin tick(); waited++; end
    check("midblock_reached", 32'(got_q.size() >= 6), 32'(1));
    rst_n = 1'b0;
    #1;
    check("arst_ch_ready", 32'(bus.ch_ready), 32'(0));
    check("arst_uart_wr",  32'(bus.uart_wr),  32'(0));
    check("arst_uart_dat", 32'(bus.uart_dat), 32'(0));
    check("arst_busy",     32'(bus.busy),     32'(0));
    check("arst_done",     32'(bus.done),     32'(0));
    check("arst_done_ch",  32'(bus.done_ch),  32'(0));
    got_q.delete();
    prev_wr = 1'b0;
    prev_done = 1'b0;
    rr_m = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_vec(2'b01, 1'b0, 1'b0, 1, 1, 1'b0, cnt, f, l);
    check("restart_first", 32'(f), 32'(8'hA0));
    repeat (2) tick();

    // Randomized transfers against the model.
    for (int r = 0; r < 8; r++) begin
      data_c[0] = {$urandom, $urandom, $urandom, $urandom};
      data_c[1] = {$urandom, $urandom, $urandom, $urandom};
      m = 2'($urandom_range(1, 3));
      run_vec(m, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
              int'(m[0]) + int'(m[1]), 1'b0, cnt, f, l);
      repeat (int'($urandom_range(1, 3))) tick();
    end

    check("protocol", 32'(viol), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
